// File: rtl/shared_reg_arbiter_if.sv
// Bus bundle between the requesting clients and the shared register arbiter.
// The master side drives the requests and write data. The slave side returns
// the grant and the register contents.
interface shared_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int OW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [OW-1:0]  owner;

  modport master (
    output req, lock, wdata,
    input  gnt, q, q_valid, owner
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, q_valid, owner
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that is the only write path into one shared W-bit register.
// A winning client may lock ownership and take back-to-back grants. The number
// of consecutive grants to a locked owner is capped at MAX_HOLD, after which the
// owner has to compete in the round-robin again. All outputs are registered.
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  shared_reg_arbiter_if.slave bus
);
  localparam int OW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, nxt_state;
  logic [OW-1:0] ptr, nxt_ptr;
  logic [HW-1:0] hold_cnt, nxt_hold;

  logic          rr_found;
  logic [OW-1:0] rr_winner;
  logic          grant;
  logic [OW-1:0] grant_idx;

  logic [N-1:0]  gnt_r;
  logic [W-1:0]  q_r;
  logic          q_valid_r;
  logic [OW-1:0] owner_r;

  assign bus.gnt     = gnt_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.owner   = owner_r;

  // Find the first requesting client, searching upward from ptr and wrapping at N.
  always_comb begin
    // NOTE: every variable gets a default before any branch. A path that leaves one unassigned would infer a latch.
    int idx;
    idx       = 0;
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!rr_found && bus.req[idx]) begin
        rr_found  = 1'b1;
        rr_winner = OW'(idx);
      end
    end
  end

  // Next state: the locked owner keeps the bus, else round-robin, else go idle.
  always_comb begin
    nxt_state = IDLE;
    nxt_ptr   = ptr;
    nxt_hold  = '0;
    grant     = 1'b0;
    grant_idx = owner_r;
    if (state == LOCKED && bus.req[owner_r] && hold_cnt < HOLD_LAST) begin
      // The owner keeps the bus. Dropping its lock still gives it this one grant.
      grant     = 1'b1;
      grant_idx = owner_r;
      nxt_hold  = hold_cnt + 1'b1;
      nxt_state = bus.lock[owner_r] ? LOCKED : IDLE;
    end else if (rr_found) begin
      // ptr moves past the winner. An owner whose hold expired therefore loses to any other requester.
      grant     = 1'b1;
      grant_idx = rr_winner;
      nxt_ptr   = (rr_winner == LAST_IDX) ? '0 : rr_winner + 1'b1;
      nxt_state = bus.lock[rr_winner] ? LOCKED : IDLE;
    end
  end

  // Register the FSM state and the outputs. q and owner hold when nobody is granted.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every flop is written with non-blocking assignments, so all of them update together from pre-edge values.
    if (!reset) begin
      // NOTE: q is a single register and not a memory array, so it is reset with everything else. Readers then see 0 after reset, never X.
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_r     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
    end else begin
      state     <= nxt_state;
      ptr       <= nxt_ptr;
      hold_cnt  <= nxt_hold;
      q_valid_r <= grant;
      if (grant) begin
        gnt_r   <= N'(1) << grant_idx;
        q_r     <= bus.wdata[int'(grant_idx)*W +: W];
        owner_r <= grant_idx;
      end else begin
        gnt_r   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter. The bench drives two instances
// with the same stimulus. One uses MAX_HOLD=4 and the other uses MAX_HOLD=1,
// where lock has no effect. A behavioural model predicts the outputs at each edge
// and pushes them into a scoreboard queue. A monitor pops the queue on the
// falling edge and compares.
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] q;
    logic         qv;
    logic [1:0]   owner;
  } exp_t;

  logic clk;
  logic reset;
  logic [N-1:0]   req_s;
  logic [N-1:0]   lock_s;
  logic [N*W-1:0] wdata_s;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  // Model state: index 0 models the MAX_HOLD=4 instance, index 1 the MAX_HOLD=1 instance.
  int         max_hold[2] = '{4, 1};
  int         m_ptr[2];
  int         m_owner[2];
  int         m_streak[2];
  bit         m_locked[2];
  logic [N-1:0] m_gnt[2];
  logic [W-1:0] m_q[2];
  bit         m_qv[2];

  shared_reg_arbiter_if #(.N(N), .W(W)) if_a ();
  shared_reg_arbiter_if #(.N(N), .W(W)) if_b ();

  assign if_a.req = req_s;  assign if_a.lock = lock_s;  assign if_a.wdata = wdata_s;
  assign if_b.req = req_s;  assign if_b.lock = lock_s;  assign if_b.wdata = wdata_s;

  shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_owner[k] = 0; m_streak[k] = 0; m_locked[k] = 0;
      m_gnt[k] = '0; m_q[k] = '0; m_qv[k] = 0;
    end
  endfunction

  // m_streak counts the grants the current owner has received in a row.
  function automatic void model_step(input int k, input logic [N-1:0] r,
                                     input logic [N-1:0] l, input logic [N*W-1:0] d);
    int win = -1;
    if (m_locked[k] && r[m_owner[k]] && m_streak[k] < max_hold[k]) begin
      win = m_owner[k];
      m_streak[k]++;
      m_locked[k] = l[win];
    end else if (r != 0) begin
      for (int i = 0; i < N; i++) begin
        int c = (m_ptr[k] + i) % N;
        if (win < 0 && r[c]) win = c;
      end
      m_ptr[k]    = (win + 1) % N;
      m_streak[k] = 1;
      m_locked[k] = l[win];
    end else begin
      m_locked[k] = 0;
    end
    if (win >= 0) begin
      m_gnt[k]   = N'(1) << win;
      m_q[k]     = d[win*W +: W];
      m_owner[k] = win;
      m_qv[k]    = 1;
    end else begin
      m_gnt[k] = '0;
      m_qv[k]  = 0;
    end
  endfunction

  // Drive one set of inputs, predict both instances, and queue the predictions after the edge.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    exp_t e;
    req_s = r; lock_s = l; wdata_s = d;
    model_step(0, r, l, d);
    model_step(1, r, l, d);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      e.gnt = m_gnt[k]; e.q = m_q[k]; e.qv = m_qv[k]; e.owner = 2'(m_owner[k]);
      exp_q.push_back(e);
    end
    #1;
  endtask

  // Assert reset in mid-cycle with random inputs. Outputs must clear without waiting for an edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    req_s = N'($urandom); lock_s = N'($urandom); wdata_s = $urandom;
    reset = 1'b0;
    #1;
    check("rst_gnt_a",   32'(if_a.gnt), 0);
    check("rst_q_a",     32'(if_a.q), 0);
    check("rst_qv_a",    32'(if_a.q_valid), 0);
    check("rst_owner_a", 32'(if_a.owner), 0);
    check("rst_gnt_b",   32'(if_b.gnt), 0);
    check("rst_q_b",     32'(if_b.q), 0);
    check("rst_qv_b",    32'(if_b.q_valid), 0);
    check("rst_owner_b", 32'(if_b.owner), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Scoreboard monitor: compare each queued prediction on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() >= 2) begin
      exp_t ea, eb;
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      check("gnt_a",   32'(if_a.gnt),     32'(ea.gnt));
      check("q_a",     32'(if_a.q),       32'(ea.q));
      check("qv_a",    32'(if_a.q_valid), 32'(ea.qv));
      check("owner_a", 32'(if_a.owner),   32'(ea.owner));
      check("gnt_b",   32'(if_b.gnt),     32'(eb.gnt));
      check("q_b",     32'(if_b.q),       32'(eb.q));
      check("qv_b",    32'(if_b.q_valid), 32'(eb.qv));
      check("owner_b", 32'(if_b.owner),   32'(eb.owner));
    end
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] l;
    reset = 1'b0; req_s = '0; lock_s = '0; wdata_s = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_gnt", 32'(if_a.gnt), 0);
    check("init_q",   32'(if_a.q), 0);
    reset = 1'b1;

    // A single client writes once. q must hold after the request goes away.
    cycle(4'b0100, 4'b0000, 32'h00A5_0000);
    cycle(4'b0000, 4'b0000, 32'h1122_3344);

    // Round robin from ptr=0 with every client requesting.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(4'b1111, 4'b0000, $urandom);

    // Client 1 locks while clients 0 and 3 also request.
    cycle(4'b0010, 4'b0010, $urandom);
    for (int i = 0; i < 7; i++) cycle(4'b1011, 4'b0010, $urandom);

    // Client 1 drops its lock before the second grant edge.
    cycle(4'b0010, 4'b0010, $urandom);
    cycle(4'b0110, 4'b0000, $urandom);
    cycle(4'b0110, 4'b0000, $urandom);

    // A locked owner that is the only requester runs past its hold limit.
    for (int i = 0; i < 7; i++) cycle(4'b0001, 4'b0001, $urandom);
    cycle(4'b0001, 4'b0001, 32'h0000_0000);

    // Reset arrives while client 2 is locked. Arbitration restarts from ptr=0.
    cycle(4'b0100, 4'b0100, $urandom);
    cycle(4'b0100, 4'b0100, $urandom);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(4'b1100, 4'b0100, $urandom);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      r = ($urandom_range(0, 3) == 0) ? req_s : N'($urandom);
      l = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
      cycle(r, l, $urandom);
    end
    cycle(4'b0000, 4'b0000, '0);

    @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one W-bit storage register among N requesters. Each clock edge it selects at most one requesting client, writes that client's data into the shared register and returns a one-cycle grant. A client may lock ownership for back-to-back writes, up to a bounded hold limit. The block sits in front of the flip-flop storage as its only write path; readers observe `q`.

## Interface
- `N`, 4: number of requesters, 2..8.
- `W`, 8: data width of the shared register.
- `MAX_HOLD`, 4: maximum consecutive grants to one locked owner, ≥1.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req`  input  N  write request, one bit per client.
- `lock`  input  N  per-client request to keep ownership for the next cycle.
- `wdata`  input  N*W  client i data in bits [i*W +: W].
- `gnt`  output  N  registered one-hot grant; at most one bit set.
- `q`  output  W  shared register contents.
- `q_valid`  output  1  `q` was written at the most recent edge.
- `owner`  output  clog2(N)  index of the last granted client.

## Operation
- Reset value of every output: `gnt`=0, `q`=0, `q_valid`=0, `owner`=0. Internal `ptr`=0, `hold_cnt`=0, FSM state = IDLE.
- FSM states:
  - IDLE: no locked owner.
  - LOCKED: `owner` holds the bus.
- Arbitration at each edge, in priority order:
  1. LOCKED and `req[owner]` and `hold_cnt` < MAX_HOLD-1: grant `owner` again, `hold_cnt`++, stay LOCKED.
  2. Otherwise, if any `req` bit is set: winner is the first set bit searching upward from `ptr`, with modulo-N wrap. Then:
     - `ptr` <= winner+1 mod N; `hold_cnt` <= 0.
     - Next state is LOCKED if `lock[winner]`, else IDLE.
  3. Otherwise (no `req`): `gnt` <= 0, `q_valid` <= 0, `q` and `owner` hold, state <= IDLE, `hold_cnt` <= 0.
- On any grant at an edge:
  - `gnt` <= onehot(winner), `q` <= `wdata[winner]`, `owner` <= winner, `q_valid` <= 1.
- In LOCKED, a change of `lock[owner]` is sampled at the grant edge:
  - `lock[owner]`=0 with `req[owner]`=1: owner is granted once more, then state returns to IDLE.
  - `req[owner]`=0: immediate rearbitration via rule 2.
- Hold-limit expiry: when `hold_cnt` reaches MAX_HOLD-1, the owner is forced through rule 2 on the next edge.
  - `ptr` is already past the owner, so any other requester wins.
  - If the owner is the only requester, it wins again with `hold_cnt` reset to 0.
- With MAX_HOLD=1, lock has no effect; behaviour is pure round-robin.
- `lock` without `req` is ignored. `wdata` of non-winners is ignored.
- Reset assertion at any time, including mid-LOCKED, immediately forces all reset values. The first edge after release arbitrates from `ptr`=0.

## Timing
- Latency: `req`/`wdata` sampled at edge k → `gnt`, `q`, `q_valid`, `owner` valid after edge k, for one cycle.
- `gnt` is a pulse per granted write, not a level. A client holding `req` is served again per the rules above.
- Client handshake:
  - A client drops `req` in the cycle it observes its `gnt` bit if it has no further data.
  - A `req` still high at the next edge is a new write.
- All outputs are registered; no combinational path from inputs to outputs.
- Fairness bound: a continuously requesting client waits at most (N-1)·MAX_HOLD grants.

## Test plan
- Reset: drive `reset`=0 mid-cycle with random inputs → `gnt`=0, `q`=0, `q_valid`=0, `owner`=0 immediately, without waiting for an edge.
- Single client: `req`=4'b0100, `wdata[2]`=8'hA5 for one edge → next cycle `gnt`=4'b0100, `q`=8'hA5, `owner`=2, `q_valid`=1. Following cycle with `req`=0 → `gnt`=0, `q_valid`=0, `q` holds 8'hA5.
- Round-robin: `req`=4'b1111, no lock, 8 edges → grant order 0,1,2,3,0,1,2,3. `q` tracks each winner's `wdata`.
- Lock with MAX_HOLD=4: client 1 with `req`+`lock` held, clients 0 and 3 requesting → client 1 gets 4 consecutive grants, then client 3, then client 0.
- Lock release: client 1 locked; drop `lock[1]` before the second grant edge → one further grant to client 1, then the next requester above index 1.
- Reset mid-LOCKED: client 2 locked with 2 grants done; pulse `reset` low; release with `req`=4'b1100 → first grant goes to client 2, since `ptr`=0, with `hold_cnt` restarted.
